// File: rtl/fetch_pkg.sv
// Shared types for the decoupled instruction-fetch front end: FSM states,
// prefetch FIFO entry layout and the canonical NOP encoding.
package fetch_pkg;

    localparam int          FETCH_XLEN = 32;
    localparam logic [31:0] INSTR_NOP  = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [31:0]           instr;
    } fetch_entry_t;

    // Harmless filler for storage that has never been written.
    function automatic fetch_entry_t nop_entry();
        fetch_entry_t e;
        e.pc    = {FETCH_XLEN{1'b0}};
        e.instr = INSTR_NOP;
        return e;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of {pc, instr} entries; flush wins over push so a
// response arriving in the flush cycle is dropped.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic [LVL_W-1:0] level
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             pop_ok_s;
    logic             push_ok_s;

    // Next-state for storage, pointers and level; pointers wrap naturally.
    always_comb begin
        pop_ok_s  = pop && (level_q != {LVL_W{1'b0}});
        push_ok_s = push && ((level_q != LVL_W'(DEPTH)) || pop_ok_s);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        if (flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            level_d  = {LVL_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= nop_entry();
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            level_q  <= {LVL_W{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/fetch_unit.sv
// Decoupled fetch front end: PC register issuing to a 1-cycle synchronous
// instruction memory, credit-limited prefetch FIFO and valid/ready to decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int             XLEN       = 32,
    parameter int             ADDR_W     = 12,
    parameter int             FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_VEC = {XLEN{1'b0}}
) (
    input  logic                               clk,
    input  logic                               rst,
    output logic                               imem_req,
    output logic [ADDR_W-1:0]                  imem_addr,
    input  logic [31:0]                        imem_rdata,
    input  logic                               redirect,
    input  logic [XLEN-1:0]                    redirect_pc,
    output logic                               if_valid,
    input  logic                               if_ready,
    output logic [31:0]                        if_instr,
    output logic [XLEN-1:0]                    if_pc,
    output logic [XLEN-1:0]                    if_pc_plus4,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

    localparam int             LVL_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [LVL_W:0] DEPTH_C = (LVL_W + 1)'(FIFO_DEPTH);

    fetch_state_t     state_q, state_d;
    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  req_pc_q, req_pc_d;
    logic             inflight_q, inflight_d;

    logic             credit_ok_s;
    logic             issue_s;
    logic             take_redirect_s;
    logic             if_valid_s;
    logic             pop_s;
    logic [LVL_W-1:0] level_s;
    logic [XLEN-1:0]  head_pc_s;
    fetch_entry_t     push_entry_s;
    fetch_entry_t     head_s;
    logic             unused_s;

    // An in-flight request holds a FIFO slot, so the FIFO can never overflow.
    assign credit_ok_s     = ({1'b0, level_s} + {{LVL_W{1'b0}}, inflight_q}) < DEPTH_C;
    assign take_redirect_s = redirect && (state_q != IDLE);
    assign issue_s         = (state_q == RUN) && !redirect && credit_ok_s;
    assign if_valid_s      = (level_s != {LVL_W{1'b0}});
    assign pop_s           = if_valid_s && if_ready;

    assign push_entry_s.pc    = FETCH_XLEN'(req_pc_q);
    assign push_entry_s.instr = imem_rdata;
    assign head_pc_s          = XLEN'(head_s.pc);
    assign unused_s           = ^redirect_pc[1:0];

    // Flushing in the redirect cycle also drops the response arriving then.
    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .flush     (take_redirect_s),
        .push      (inflight_q),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .head      (head_s),
        .level     (level_s)
    );

    // FSM next-state plus fetch PC / request bookkeeping.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = issue_s;
        case (state_q)
            IDLE:    state_d = RUN;
            RUN:     state_d = take_redirect_s ? FLUSH : RUN;
            FLUSH:   state_d = take_redirect_s ? FLUSH : RUN;
            default: state_d = IDLE;
        endcase
        if (take_redirect_s) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (issue_s) begin
            fetch_pc_d = fetch_pc_q + XLEN'(32'd4);
            req_pc_d   = fetch_pc_q;
        end else begin
            fetch_pc_d = fetch_pc_q;
            req_pc_d   = req_pc_q;
        end
    end

    // FSM and fetch-side registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_VEC;
            req_pc_q   <= {XLEN{1'b0}};
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

    assign imem_req    = issue_s;
    assign imem_addr   = fetch_pc_q[ADDR_W-1:0];
    assign if_valid    = if_valid_s;
    assign if_instr    = if_valid_s ? head_s.instr : 32'h0000_0000;
    assign if_pc       = if_valid_s ? head_pc_s : {XLEN{1'b0}};
    assign if_pc_plus4 = if_valid_s ? (head_pc_s + XLEN'(32'd4)) : {XLEN{1'b0}};
    assign fifo_level  = level_s;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: cycle table, directed redirect/wrap/reset
// sequences, and a randomized run checked by a stream-level reference model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [2:0]  fifo_level;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN       (32),
        .ADDR_W     (12),
        .FIFO_DEPTH (4),
        .RESET_VEC  (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_plus4 (if_pc_plus4),
        .fifo_level  (fifo_level)
    );

    function automatic logic [31:0] mem_word(input logic [11:0] a);
        return {8'hC3, a, ~a};
    endfunction

    // 1-cycle synchronous memory; garbage when not requested.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? mem_word(imem_addr) : $urandom();
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        if_ready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Stream-level reference: delivered PCs and request addresses each form
    // a +4 sequence restarting at the reset vector or the aligned redirect target.
    logic [31:0] m_deliver;
    logic [31:0] m_req;
    logic        prev_req;
    int          since_rst;
    int          stall;

    always @(negedge clk) begin
        if (!rst) begin
            m_deliver = 32'h0;
            m_req     = 32'h0;
            prev_req  = 1'b0;
            since_rst = 0;
            stall     = 0;
        end else begin
            chk("m_valid_vs_level", 32'(if_valid), 32'(fifo_level != 3'd0));
            chk("m_level_max", 32'(fifo_level <= 3'd4), 32'd1);
            if (!if_valid) begin
                chk("m_zero_when_empty", if_instr | if_pc | if_pc_plus4, 32'h0);
            end else if (if_ready) begin
                chk("m_pop_pc", if_pc, m_deliver);
                chk("m_pop_instr", if_instr, mem_word(m_deliver[11:0]));
                chk("m_pop_pc4", if_pc_plus4, m_deliver + 32'd4);
                m_deliver = m_deliver + 32'd4;
            end
            if (imem_req) begin
                chk("m_req_in_redirect", 32'(redirect), 32'd0);
                chk("m_credit", 32'((int'(fifo_level) + int'(prev_req)) < 4), 32'd1);
                chk("m_req_addr", 32'(imem_addr), 32'(m_req[11:0]));
                m_req = m_req + 32'd4;
            end
            if (redirect && since_rst > 0) begin
                m_deliver = {redirect_pc[31:2], 2'b00};
                m_req     = {redirect_pc[31:2], 2'b00};
                stall     = 0;
            end else if (if_ready && !if_valid) begin
                stall++;
                if (stall > 8) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL m_stall: got %0d empty cycles expected at most 8", stall);
                    stall = 0;
                end
            end else begin
                stall = 0;
            end
            prev_req = imem_req;
            since_rst++;
        end
    end

    typedef struct {
        logic        rdy;
        logic        req;
        logic [11:0] addr;
        logic        vld;
        logic [31:0] pc;
        logic [2:0]  lvl;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic seen_a;
        logic seen_b;

        // Cycle 0 = IDLE after reset release; if_ready held low, then raised.
        tbl[0]  = '{1'b0, 1'b0, 12'h000, 1'b0, 32'h00, 3'd0};
        tbl[1]  = '{1'b0, 1'b1, 12'h000, 1'b0, 32'h00, 3'd0};
        tbl[2]  = '{1'b0, 1'b1, 12'h004, 1'b0, 32'h00, 3'd0};
        tbl[3]  = '{1'b0, 1'b1, 12'h008, 1'b1, 32'h00, 3'd1};
        tbl[4]  = '{1'b0, 1'b1, 12'h00C, 1'b1, 32'h00, 3'd2};
        tbl[5]  = '{1'b0, 1'b0, 12'h000, 1'b1, 32'h00, 3'd3};
        tbl[6]  = '{1'b0, 1'b0, 12'h000, 1'b1, 32'h00, 3'd4};
        tbl[7]  = '{1'b0, 1'b0, 12'h000, 1'b1, 32'h00, 3'd4};
        tbl[8]  = '{1'b1, 1'b0, 12'h000, 1'b1, 32'h00, 3'd4};
        tbl[9]  = '{1'b1, 1'b1, 12'h010, 1'b1, 32'h04, 3'd3};
        tbl[10] = '{1'b1, 1'b1, 12'h014, 1'b1, 32'h08, 3'd2};
        tbl[11] = '{1'b1, 1'b1, 12'h018, 1'b1, 32'h0C, 3'd2};
        tbl[12] = '{1'b1, 1'b1, 12'h01C, 1'b1, 32'h10, 3'd2};

        rst = 1'b0;
        do_reset();
        chk("reset_level", 32'(fifo_level), 32'd0);
        for (int i = 0; i < 13; i++) begin
            if_ready = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("tbl_req_c%0d", i), 32'(imem_req), 32'(tbl[i].req));
            if (tbl[i].req) chk($sformatf("tbl_addr_c%0d", i), 32'(imem_addr), 32'(tbl[i].addr));
            chk($sformatf("tbl_valid_c%0d", i), 32'(if_valid), 32'(tbl[i].vld));
            chk($sformatf("tbl_pc_c%0d", i), if_pc, tbl[i].pc);
            chk($sformatf("tbl_level_c%0d", i), 32'(fifo_level), 32'(tbl[i].lvl));
            step();
        end

        // Redirect to 0x103 with 3 entries queued and one response in flight.
        do_reset();
        repeat (5) step();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        @(negedge clk);
        chk("rd_level_before", 32'(fifo_level), 32'd3);
        chk("rd_req_in_redirect", 32'(imem_req), 32'd0);
        step();
        redirect = 1'b0;
        if_ready = 1'b1;
        @(negedge clk);
        chk("rd_level_cleared", 32'(fifo_level), 32'd0);
        chk("rd_valid_cleared", 32'(if_valid), 32'd0);
        chk("rd_flush_bubble", 32'(imem_req), 32'd0);
        step();
        @(negedge clk);
        chk("rd_first_req", 32'(imem_req), 32'd1);
        chk("rd_first_addr", 32'(imem_addr), 32'h100);
        step();
        @(negedge clk);
        chk("rd_latency_gap", 32'(if_valid), 32'd0);
        step();
        @(negedge clk);
        chk("rd_first_valid", 32'(if_valid), 32'd1);
        chk("rd_first_pc", if_pc, 32'h0000_0100);
        step();
        repeat (8) step();

        // Back-to-back redirects: only the second target's stream survives.
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0040;
        @(negedge clk);
        chk("b2b_req_r0", 32'(imem_req), 32'd0);
        step();
        redirect_pc = 32'h0000_0080;
        @(negedge clk);
        chk("b2b_req_r1", 32'(imem_req), 32'd0);
        chk("b2b_valid_r1", 32'(if_valid), 32'd0);
        step();
        redirect = 1'b0;
        @(negedge clk);
        chk("b2b_bubble", 32'(imem_req), 32'd0);
        step();
        @(negedge clk);
        chk("b2b_req", 32'(imem_req), 32'd1);
        chk("b2b_addr", 32'(imem_addr), 32'h080);
        step();
        step();
        @(negedge clk);
        chk("b2b_pc", if_pc, 32'h0000_0080);
        step();
        repeat (10) step();

        // imem_addr wraps at 2^ADDR_W while the PC keeps counting.
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0FF8;
        step();
        redirect = 1'b0;
        step();
        @(negedge clk);
        chk("aw_addr_ff8", 32'(imem_addr), 32'hFF8);
        step();
        @(negedge clk);
        chk("aw_addr_ffc", 32'(imem_addr), 32'hFFC);
        step();
        @(negedge clk);
        chk("aw_req_wrap", 32'(imem_req), 32'd1);
        chk("aw_addr_000", 32'(imem_addr), 32'h000);
        step();
        seen_a = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (if_valid && if_pc == 32'h0000_1000) seen_a = 1'b1;
            step();
        end
        chk("aw_pc_1000_seen", 32'(seen_a), 32'd1);

        // PC wraps mod 2^XLEN.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect = 1'b0;
        seen_a   = 1'b0;
        seen_b   = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (if_valid && if_pc == 32'hFFFF_FFFC) begin
                seen_a = 1'b1;
                chk("xw_pc4_wrap", if_pc_plus4, 32'h0000_0000);
            end
            if (if_valid && seen_a && if_pc == 32'h0000_0000) seen_b = 1'b1;
            step();
        end
        chk("xw_seen_fffc", 32'(seen_a), 32'd1);
        chk("xw_seen_0", 32'(seen_b), 32'd1);

        // Asynchronous reset mid-stream with the FIFO full.
        do_reset();
        repeat (8) step();
        @(negedge clk);
        chk("ar_full_level", 32'(fifo_level), 32'd4);
        step();
        #2;
        rst = 1'b0;
        #1;
        chk("ar_req", 32'(imem_req), 32'd0);
        chk("ar_valid", 32'(if_valid), 32'd0);
        chk("ar_level", 32'(fifo_level), 32'd0);
        chk("ar_zero", if_instr | if_pc | if_pc_plus4, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("ar_idle_req", 32'(imem_req), 32'd0);
        step();
        @(negedge clk);
        chk("ar_restart_req", 32'(imem_req), 32'd1);
        chk("ar_restart_addr", 32'(imem_addr), 32'h000);
        step();
        step();
        @(negedge clk);
        chk("ar_restart_pc", if_pc, 32'h0000_0000);
        chk("ar_restart_valid", 32'(if_valid), 32'd1);
        step();

        // Randomized traffic checked by the stream model.
        for (int i = 0; i < 1500; i++) begin
            if_ready = ($urandom_range(0, 3) != 0);
            redirect = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 2))
                0:       redirect_pc = 32'($urandom_range(0, 4095));
                1:       redirect_pc = 32'hFFFF_FF00 | ($urandom() & 32'h0000_00FF);
                default: redirect_pc = $urandom();
            endcase
            step();
        end
        redirect = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
